// File: rtl/acc_burst_feeder.sv
// Sample FIFO feeding a running accumulator. A start command clears the accumulator and
// then streams burst_len samples into it, driving zero on every cycle with no sample.
module acc_burst_feeder #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int LW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     start,
  input  logic [LW-1:0]            burst_len,
  output logic [DW-1:0]            acc_in,
  output logic                     acc_clr,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  state_t        r_state, w_state_nxt;
  logic [LW-1:0] r_len, r_cnt, w_len_nxt, w_cnt_nxt;
  logic [DW-1:0] r_acc_in, w_acc_in_nxt;
  logic          r_acc_clr, w_acc_clr_nxt;
  logic          r_done, w_done_nxt;
  logic          w_push, w_pop;

  // Full blocks a push even when a pop happens on the same edge; level only counts
  // stored words, so a word cannot be popped on the edge that writes it.
  assign s_ready = (r_level != (AW+1)'(DEPTH));
  assign w_push  = s_valid & s_ready;
  assign w_pop   = (r_state == FEED) && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_acc_in  <= '0;
      r_acc_clr <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_cnt     <= w_cnt_nxt;
      r_acc_in  <= w_acc_in_nxt;
      r_acc_clr <= w_acc_clr_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_acc_in_nxt  = '0;
    w_acc_clr_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_len_nxt     = burst_len;
          w_cnt_nxt     = '0;
          w_acc_clr_nxt = 1'b1;
          w_state_nxt   = CLEAR;
        end
      end
      CLEAR: begin
        if (r_len == '0) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = FEED;
        end
      end
      FEED: begin
        // cnt < len here, so cnt+1 never wraps even for len = 2^LW-1
        if (w_pop) begin
          w_acc_in_nxt = r_mem[r_rptr];
          w_cnt_nxt    = r_cnt + LW'(1);
          if ((r_cnt + LW'(1)) == r_len) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign acc_in  = r_acc_in;
  assign acc_clr = r_acc_clr;
  assign done    = r_done;
  assign busy    = (r_state == CLEAR) || (r_state == FEED);
  assign level   = r_level;

endmodule

// File: tb/tb_acc_burst_feeder.sv
// Directed bench for acc_burst_feeder with a simple accumulator model on acc_in/acc_clr.
module tb_acc_burst_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        start;
  logic [7:0]  burst_len;
  logic [15:0] acc_in;
  logic        acc_clr;
  logic        busy;
  logic        done;
  logic [3:0]  level;
  logic [15:0] acc;

  int checks = 0;
  int errors = 0;

  acc_burst_feeder #(.DW(16), .DEPTH(8), .LW(8)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .burst_len(burst_len), .acc_in(acc_in), .acc_clr(acc_clr),
    .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  // downstream accumulator: synchronous clear, adds acc_in every edge
  always @(posedge clk or posedge reset) begin
    if (reset)        acc <= '0;
    else if (acc_clr) acc <= '0;
    else              acc <= acc + acc_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; burst_len = '0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({acc_in, acc_clr, busy, done, s_ready, level} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_values got %h exp %h", {acc_in, acc_clr, busy, done, s_ready, level}, 24'h000010);
    end
    push(16'hAAAA); push(16'h5555);
    checks++;
    if (level !== 4'd2) begin
      errors++; $display("FAIL reset_prefill level got %0d exp 2", level);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({acc_in, acc_clr, busy, done, s_ready, level} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", {acc_in, acc_clr, busy, done, s_ready, level}, 24'h000010);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] ein [6] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    logic        eclr[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        edn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ebsy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  elv [6] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    push(16'd1); push(16'd2); push(16'd3);
    start = 1'b1; burst_len = 8'd3;
    for (int k = 0; k < 6; k++) begin
      step();
      start = 1'b0;
      checks++;
      if ({acc_in, acc_clr, done, busy, level} !== {ein[k], eclr[k], edn[k], ebsy[k], elv[k]}) begin
        errors++;
        $display("FAIL basic k=%0d got %h exp %h", k,
                 {acc_in, acc_clr, done, busy, level}, {ein[k], eclr[k], edn[k], ebsy[k], elv[k]});
      end
    end
    checks++;
    if (acc !== 16'd6) begin
      errors++; $display("FAIL basic_sum got %0d exp 6", acc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] ein [10] = '{16'd0, 16'd0, 16'd10, 16'd20, 16'd0, 16'd0, 16'd0, 16'd30, 16'd40, 16'd0};
    logic        edn [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ebsy[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  elv [10] = '{4'd2, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd0};
    push(16'd10); push(16'd20);
    start = 1'b1; burst_len = 8'd4;
    for (int k = 0; k < 10; k++) begin
      step();
      start = 1'b0;
      checks++;
      if ({acc_in, done, busy, level} !== {ein[k], edn[k], ebsy[k], elv[k]}) begin
        errors++;
        $display("FAIL stall k=%0d got %h exp %h", k,
                 {acc_in, done, busy, level}, {ein[k], edn[k], ebsy[k], elv[k]});
      end
      if (k == 5) begin s_valid = 1'b1; s_data = 16'd30; end
      if (k == 6) s_data = 16'd40;
      if (k == 7) s_valid = 1'b0;
    end
    checks++;
    if (acc !== 16'd100) begin
      errors++; $display("FAIL stall_sum got %0d exp 100", acc);
    end
  endtask

  task automatic test_full();
    logic [15:0] ein [4] = '{16'd0, 16'd0, 16'd1, 16'd0};
    logic        edn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        erdy[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  elv [4] = '{4'd8, 4'd8, 4'd7, 4'd8};
    for (int i = 1; i <= 8; i++) push(16'(i));
    checks++;
    if ({s_ready, level} !== {1'b0, 4'd8}) begin
      errors++; $display("FAIL full_level got rdy=%b lvl=%0d exp rdy=0 lvl=8", s_ready, level);
    end
    s_valid = 1'b1; s_data = 16'd9;
    step();
    checks++;
    if ({s_ready, level} !== {1'b0, 4'd8}) begin
      errors++; $display("FAIL full_hold got rdy=%b lvl=%0d exp rdy=0 lvl=8", s_ready, level);
    end
    start = 1'b1; burst_len = 8'd1;
    for (int k = 0; k < 4; k++) begin
      step();
      start = 1'b0;
      checks++;
      if ({acc_in, done, s_ready, level} !== {ein[k], edn[k], erdy[k], elv[k]}) begin
        errors++;
        $display("FAIL full k=%0d got %h exp %h", k,
                 {acc_in, done, s_ready, level}, {ein[k], edn[k], erdy[k], elv[k]});
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_zero_length();
    logic        eclr[3] = '{1'b1, 1'b0, 1'b0};
    logic        edn [3] = '{1'b0, 1'b1, 1'b0};
    logic        ebsy[3] = '{1'b1, 1'b0, 1'b0};
    start = 1'b1; burst_len = 8'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      start = 1'b0;
      checks++;
      if ({acc_in, acc_clr, done, busy, level} !== {16'd0, eclr[k], edn[k], ebsy[k], 4'd8}) begin
        errors++;
        $display("FAIL zero_len k=%0d got %h exp %h", k,
                 {acc_in, acc_clr, done, busy, level}, {16'd0, eclr[k], edn[k], ebsy[k], 4'd8});
      end
    end
    checks++;
    if (acc !== 16'd0) begin
      errors++; $display("FAIL zero_len_sum got %0d exp 0", acc);
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] ein [11] = '{16'd0, 16'd0, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd0};
    logic        eclr[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        edn [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ebsy[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  elv [11] = '{4'd8, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    start = 1'b1; burst_len = 8'd8;
    for (int k = 0; k < 11; k++) begin
      step();
      burst_len = 8'd2;
      checks++;
      if ({acc_in, acc_clr, done, busy, level} !== {ein[k], eclr[k], edn[k], ebsy[k], elv[k]}) begin
        errors++;
        $display("FAIL start_busy k=%0d got %h exp %h", k,
                 {acc_in, acc_clr, done, busy, level}, {ein[k], eclr[k], edn[k], ebsy[k], elv[k]});
      end
    end
    start = 1'b0;
    checks++;
    if (acc !== 16'd44) begin
      errors++; $display("FAIL start_busy_sum got %0d exp 44", acc);
    end
    step();
  endtask

  task automatic test_reset_mid_feed();
    push(16'd5); push(16'd6); push(16'd7);
    start = 1'b1; burst_len = 8'd3;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if ({acc_in, busy, level} !== {16'd5, 1'b1, 4'd2}) begin
      errors++; $display("FAIL midfeed_pre got %h exp %h", {acc_in, busy, level}, {16'd5, 1'b1, 4'd2});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({acc_in, acc_clr, done, busy, s_ready, level} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL midfeed_reset got %h exp %h", {acc_in, acc_clr, done, busy, s_ready, level}, 24'h000010);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({done, busy, level} !== {1'b0, 1'b0, 4'd0}) begin
        errors++; $display("FAIL midfeed_after k=%0d got %h exp %h", k, {done, busy, level}, 6'h0);
      end
    end
    push(16'hFFFF); push(16'h0003);
    start = 1'b1; burst_len = 8'd2;
    step();
    start = 1'b0;
    step(); step(); step();
    checks++;
    if ({acc_in, done} !== {16'h0003, 1'b1}) begin
      errors++; $display("FAIL newburst_last got %h exp %h", {acc_in, done}, {16'h0003, 1'b1});
    end
    step();
    checks++;
    if ({acc, done, level} !== {16'h0002, 1'b0, 4'd0}) begin
      errors++; $display("FAIL newburst_sum got %h exp %h", {acc, done, level}, {16'h0002, 1'b0, 4'd0});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_zero_length();
    test_start_ignored();
    test_reset_mid_feed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
